reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order retirement queue of the Tomasulo core. Allocates one ROB tag per issued
//  instruction and returns it to the rename stage. Captures results broadcast on the CDB.
//  Retires the head entry in program order, driving the commit_* bus into the register file,
//  store-release pulses into the LSB, and jump_flag/jump_pc for a mispredict flush of the whole core.
// PARAMETERS
//  ROB_LOG   `ROB_LOG (4)   tag width; depth ROB_SIZE = 2**ROB_LOG entries
// PORTS
//  clk               in   1        rising-edge clock
//  rst_n             in   1        asynchronous reset, active-low
//  rdy               in   1        global stall; low = hold all state, outputs keep value
//  issue_valid       in   1        allocate one entry this cycle (ignored if rob_full or jump_flag)
//  issue_type        in   2        0=ALU/LOAD (writes rd), 1=BRANCH, 2=STORE, 3=JUMP (writes rd, may mispredict)
//  issue_rd          in   5        destination architectural register
//  issue_pc          in   32       instruction PC (debug/next-pc default)
//  issue_RobId       out  ROB_LOG  tag that an allocation this cycle receives (= tail)
//  rob_full          out  1        count == ROB_SIZE
//  cdb_valid         in   1        result broadcast
//  cdb_RobId         in   ROB_LOG  entry being completed
//  cdb_value         in   32       result value (rd write data)
//  cdb_mispredict    in   1        BRANCH/JUMP resolved against the prediction
//  cdb_next_pc       in   32       correct fetch PC when cdb_mispredict
//  commit_valid      out  1        one-cycle pulse: head entry with rd retired
//  commit_dest       out  5        rd of retired entry
//  commit_value      out  32       value of retired entry
//  commit_RobId      out  ROB_LOG  tag of retired entry
//  store_commit      out  1        one-cycle pulse: STORE at head released to LSB
//  store_RobId       out  ROB_LOG  tag of released store
//  jump_flag         out  1        one-cycle flush pulse on mispredict retire
//  jump_pc           out  32       redirect PC, valid with jump_flag
// BEHAVIOUR
//  - Reset (rst_n=0, async): head=tail=count=0, all busy/ready bits 0; every output 0 except
//    issue_RobId=0 and rob_full=0.
//  - Entry fields: busy, ready, type, rd, value, mispredict, next_pc, pc.
//  - Allocate: issue_valid & ~rob_full & ~jump_flag -> entry[tail] busy=1, ready=0; tail+1 mod
//    ROB_SIZE. issue_RobId/rob_full are combinational from current tail/count.
//  - Writeback: cdb_valid -> entry[cdb_RobId].ready=1 and value/mispredict/next_pc latched.
//    A CDB write to a non-busy entry is ignored.
//  - Retire (registered, at most 1/cycle): if entry[head].busy & ready, then at the next edge
//    the entry is freed and head+1. Outputs pulse for exactly one cycle:
//    types 0/3 -> commit_valid with dest/value/RobId (rd=0 still pulses; the regfile discards it);
//    type 2 -> store_commit;
//    mispredict (type 1/3) -> jump_flag=1, jump_pc=next_pc.
//  - Latency: CDB at edge N sets ready; the earliest retire pulse is visible after edge N+1.
//    A CDB hit on head in the same cycle does not retire that cycle.
//  - count: +1 on alloc, -1 on retire, unchanged on both; full/empty derived from count, never
//    from head==tail alone.
//  - Full: alloc blocked even if a retire happens the same cycle (no same-cycle slot reuse).
//  - Empty: no retire; outputs deassert.
//  - Flush: the cycle after a mispredict retire (jump_flag=1), all busy bits clear, head=tail=count=0.
//    issue_valid and cdb_valid that cycle are ignored. A JUMP with rd asserts commit_valid and
//    jump_flag together.
//  - Wrap-around: pointers are ROB_LOG bits and wrap naturally; tag = slot index.
//  - rdy=0: no state change; pulses extend only if rdy low on the pulse cycle (consumers also stall).
// STRUCTURE
//  - `config.v` holds ROB_LOG/ROB_SIZE and the ROB type codes `ROB_ALU/`ROB_BR/`ROB_ST/`ROB_JMP,
//    shared with the RS, LSB and issue unit.
//  - One module. Entry storage as per-field reg arrays; retire logic is a single always block.
//  - No sub-module is needed; pointer/count update is three lines, not worth a counter block.
// TESTING
//  - Reset: rst_n low mid-traffic with count=5 -> all outputs 0 immediately, rob_full=0, issue_RobId=0.
//  - In-order retire: issue tags 0,1,2 (ALU rd=1,2,3), CDB 2 then 0 then 1 -> commit_RobId 0,1,2
//    in order, values match.
//  - Full: 16 issues without CDB -> rob_full=1, 17th issue ignored, tail stays 0; one retire
//    -> rob_full=0 the next cycle.
//  - Wrap: 20 issue/retire pairs -> tags wrap 15->0, count never exceeds 16.
//  - Mispredict: BRANCH tag 3 with cdb_mispredict=1, cdb_next_pc=0x100, younger entries 4-6 ->
//    jump_flag pulse with jump_pc=0x100; tags 4-6 never commit; the next issue gets tag 0.
//  - Store: STORE at head ready -> store_commit=1 with store_RobId for one cycle, commit_valid=0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: ROB geometry and instruction type codes shared with RS, LSB and issue unit
`timescale 1ns/1ps
package reorder_buffer_pkg;
    localparam int ROB_LOG = 4;
    localparam int ROB_SIZE = 2**ROB_LOG;
    localparam logic [ROB_LOG:0] ROB_FULL_CNT = ROB_SIZE[ROB_LOG:0];
    localparam logic [1:0] ROB_ALU = 2'd0;
    localparam logic [1:0] ROB_BR = 2'd1;
    localparam logic [1:0] ROB_ST = 2'd2;
    localparam logic [1:0] ROB_JMP = 2'd3;
    function automatic logic writes_rd(input logic [1:0] t);
        return t == ROB_ALU || t == ROB_JMP;
    endfunction
    function automatic logic may_redirect(input logic [1:0] t);
        return t == ROB_BR || t == ROB_JMP;
    endfunction
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement queue of the Tomasulo core
// Ports:
//   clk, rst_n (async, active-low), rdy (global stall, low = hold everything)
//   issue_*  : allocation request; issue_RobId/rob_full are combinational from tail/count
//   cdb_*    : result broadcast that marks an entry ready
//   commit_* : one-cycle retire pulse for entries that write rd (ALU/LOAD, JUMP)
//   store_*  : one-cycle release pulse for a STORE reaching the head
//   jump_*   : one-cycle flush pulse with redirect PC on a mispredicted retire
`timescale 1ns/1ps
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rdy,
    input  logic               issue_valid,
    input  logic [1:0]         issue_type,
    input  logic [4:0]         issue_rd,
    input  logic [31:0]        issue_pc,
    output logic [ROB_LOG-1:0] issue_RobId,
    output logic               rob_full,
    input  logic               cdb_valid,
    input  logic [ROB_LOG-1:0] cdb_RobId,
    input  logic [31:0]        cdb_value,
    input  logic               cdb_mispredict,
    input  logic [31:0]        cdb_next_pc,
    output logic               commit_valid,
    output logic [4:0]         commit_dest,
    output logic [31:0]        commit_value,
    output logic [ROB_LOG-1:0] commit_RobId,
    output logic               store_commit,
    output logic [ROB_LOG-1:0] store_RobId,
    output logic               jump_flag,
    output logic [31:0]        jump_pc
);
    logic [ROB_LOG-1:0] r_head, r_tail;
    logic [ROB_LOG:0]   r_count;
    logic [ROB_SIZE-1:0] r_busy, r_ready, r_mis;
    logic [1:0]  r_type  [ROB_SIZE];
    logic [4:0]  r_rd    [ROB_SIZE];
    logic [31:0] r_value [ROB_SIZE];
    logic [31:0] r_npc   [ROB_SIZE];
    logic [31:0] r_pc    [ROB_SIZE];
    logic w_alloc, w_retire, w_cdb_hit, w_jump;
    assign issue_RobId = r_tail;
    assign rob_full = r_count == ROB_FULL_CNT;
    // jump_flag high means this edge is the flush edge: nothing else may touch state
    assign w_retire = r_busy[r_head] & r_ready[r_head] & ~jump_flag;
    assign w_alloc = issue_valid & ~rob_full & ~jump_flag;
    assign w_cdb_hit = cdb_valid & r_busy[cdb_RobId] & ~jump_flag;
    assign w_jump = w_retire & r_mis[r_head] & may_redirect(r_type[r_head]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_count <= '0;
            r_busy <= '0;
            r_ready <= '0;
            commit_valid <= 1'b0;
            commit_dest <= '0;
            commit_value <= '0;
            commit_RobId <= '0;
            store_commit <= 1'b0;
            store_RobId <= '0;
            jump_flag <= 1'b0;
            jump_pc <= '0;
        end else if (rdy) begin
            commit_valid <= w_retire & writes_rd(r_type[r_head]);
            store_commit <= w_retire & (r_type[r_head] == ROB_ST);
            jump_flag <= w_jump;
            if (w_retire) begin
                commit_dest <= r_rd[r_head];
                commit_value <= r_value[r_head];
                commit_RobId <= r_head;
                store_RobId <= r_head;
                // without a redirect the fall-through PC is the natural next fetch address
                jump_pc <= w_jump ? r_npc[r_head] : r_pc[r_head] + 32'd4;
            end
            if (jump_flag) begin
                r_head <= '0;
                r_tail <= '0;
                r_count <= '0;
                r_busy <= '0;
                r_ready <= '0;
            end else begin
                if (w_cdb_hit) r_ready[cdb_RobId] <= 1'b1;
                if (w_retire) begin
                    r_busy[r_head] <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head <= r_head + 1'b1;
                end
                if (w_alloc) begin
                    r_busy[r_tail] <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail <= r_tail + 1'b1;
                end
                r_count <= r_count + {{ROB_LOG{1'b0}}, w_alloc} - {{ROB_LOG{1'b0}}, w_retire};
            end
        end
    end
    // payload fields need no reset: busy/ready gate every use of them
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (w_cdb_hit) begin
                r_value[cdb_RobId] <= cdb_value;
                r_mis[cdb_RobId] <= cdb_mispredict;
                r_npc[cdb_RobId] <= cdb_next_pc;
            end
            if (w_alloc) begin
                r_type[r_tail] <= issue_type;
                r_rd[r_tail] <= issue_rd;
                r_pc[r_tail] <= issue_pc;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed table, corner sequences and queue-model random check of reorder_buffer
`timescale 1ns/1ps
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    logic issue_valid = 1'b0;
    logic [1:0] issue_type = '0;
    logic [4:0] issue_rd = '0;
    logic [31:0] issue_pc = '0;
    logic [3:0] issue_RobId;
    logic rob_full;
    logic cdb_valid = 1'b0;
    logic [3:0] cdb_RobId = '0;
    logic [31:0] cdb_value = '0;
    logic cdb_mispredict = 1'b0;
    logic [31:0] cdb_next_pc = '0;
    logic commit_valid;
    logic [4:0] commit_dest;
    logic [31:0] commit_value;
    logic [3:0] commit_RobId;
    logic store_commit;
    logic [3:0] store_RobId;
    logic jump_flag;
    logic [31:0] jump_pc;

    int n_tests = 0;
    int n_fail = 0;

    reorder_buffer dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd), .issue_pc(issue_pc),
        .issue_RobId(issue_RobId), .rob_full(rob_full),
        .cdb_valid(cdb_valid), .cdb_RobId(cdb_RobId), .cdb_value(cdb_value),
        .cdb_mispredict(cdb_mispredict), .cdb_next_pc(cdb_next_pc),
        .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_value(commit_value),
        .commit_RobId(commit_RobId), .store_commit(store_commit), .store_RobId(store_RobId),
        .jump_flag(jump_flag), .jump_pc(jump_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int iv, ty, rd, pc, cdv, cid, cval, cmis, cnpc;
        int x_cv, x_rid, x_dest, x_val, x_sc, x_srid, x_jf, x_jpc, x_irid, x_full;
    } vec_t;
    vec_t tbl [27];

    typedef struct {
        int tag;
        int ty;
        int rd;
        logic [31:0] pc;
        bit done;
        logic [31:0] val;
        bit mis;
        logic [31:0] npc;
    } ent_t;
    ent_t q[$];
    int m_tail;
    bit e_cv, e_sc, e_jf;
    int e_rid, e_dest, e_srid;
    logic [31:0] e_val, e_jpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        cdb_valid = 1'b0;
        cdb_mispredict = 1'b0;
    endtask

    task automatic issue(input int ty, input int rd, input logic [31:0] pc);
        issue_valid = 1'b1;
        issue_type = 2'(ty);
        issue_rd = 5'(rd);
        issue_pc = pc;
    endtask

    task automatic cdb(input int id, input logic [31:0] val, input bit mis, input logic [31:0] npc);
        cdb_valid = 1'b1;
        cdb_RobId = 4'(id);
        cdb_value = val;
        cdb_mispredict = mis;
        cdb_next_pc = npc;
    endtask

    task automatic do_reset();
        idle();
        rdy = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Expected outputs after one edge: the ROB is a queue of live instructions in program order.
    task automatic model_edge();
        bit ret, full;
        ent_t h;
        if (!rdy) return;
        if (e_jf) begin
            q.delete();
            m_tail = 0;
            e_cv = 0;
            e_sc = 0;
            e_jf = 0;
            return;
        end
        ret = q.size() > 0 && q[0].done;
        full = q.size() == 16;
        if (ret) h = q[0];
        if (cdb_valid)
            foreach (q[k])
                if (q[k].tag == int'(cdb_RobId)) begin
                    q[k].done = 1;
                    q[k].val = cdb_value;
                    q[k].mis = cdb_mispredict;
                    q[k].npc = cdb_next_pc;
                end
        e_cv = ret && (h.ty == 0 || h.ty == 3);
        e_sc = ret && h.ty == 2;
        e_jf = ret && h.mis && (h.ty == 1 || h.ty == 3);
        if (ret) begin
            e_rid = h.tag;
            e_dest = h.rd;
            e_val = h.val;
            e_srid = h.tag;
            if (e_jf) e_jpc = h.npc;
            void'(q.pop_front());
        end
        if (issue_valid && !full) begin
            q.push_back('{m_tail, int'(issue_type), int'(issue_rd), issue_pc, 0, 0, 0, 0});
            m_tail = (m_tail + 1) % 16;
        end
    endtask

    initial begin
        tbl[0]  = '{1,0,1,0, 0,0,0,0,0,         0,0,0,0, 0,0, 0,0, 1,0};
        tbl[1]  = '{1,0,2,0, 0,0,0,0,0,         0,0,0,0, 0,0, 0,0, 2,0};
        tbl[2]  = '{1,0,3,0, 0,0,0,0,0,         0,0,0,0, 0,0, 0,0, 3,0};
        tbl[3]  = '{0,0,0,0, 1,2,'h22,0,0,      0,0,0,0, 0,0, 0,0, 3,0};
        tbl[4]  = '{0,0,0,0, 1,0,'h20,0,0,      0,0,0,0, 0,0, 0,0, 3,0};
        tbl[5]  = '{0,0,0,0, 1,1,'h21,0,0,      1,0,1,'h20, 0,0, 0,0, 3,0};
        tbl[6]  = '{0,0,0,0, 0,0,0,0,0,         1,1,2,'h21, 0,0, 0,0, 3,0};
        tbl[7]  = '{0,0,0,0, 0,0,0,0,0,         1,2,3,'h22, 0,0, 0,0, 3,0};
        tbl[8]  = '{0,0,0,0, 0,0,0,0,0,         0,0,0,0, 0,0, 0,0, 3,0};
        tbl[9]  = '{1,2,0,0, 0,0,0,0,0,         0,0,0,0, 0,0, 0,0, 4,0};
        tbl[10] = '{0,0,0,0, 1,3,0,0,0,         0,0,0,0, 0,0, 0,0, 4,0};
        tbl[11] = '{0,0,0,0, 0,0,0,0,0,         0,0,0,0, 1,3, 0,0, 4,0};
        tbl[12] = '{0,0,0,0, 0,0,0,0,0,         0,0,0,0, 0,0, 0,0, 4,0};
        tbl[13] = '{1,1,0,0, 0,0,0,0,0,         0,0,0,0, 0,0, 0,0, 5,0};
        tbl[14] = '{1,0,5,0, 0,0,0,0,0,         0,0,0,0, 0,0, 0,0, 6,0};
        tbl[15] = '{1,0,6,0, 0,0,0,0,0,         0,0,0,0, 0,0, 0,0, 7,0};
        tbl[16] = '{1,0,7,0, 1,4,0,1,'h100,     0,0,0,0, 0,0, 0,0, 8,0};
        tbl[17] = '{0,0,0,0, 1,5,'h55,0,0,      0,0,0,0, 0,0, 1,'h100, 8,0};
        tbl[18] = '{1,0,1,0, 1,6,1,0,0,         0,0,0,0, 0,0, 0,0, 0,0};
        tbl[19] = '{0,0,0,0, 0,0,0,0,0,         0,0,0,0, 0,0, 0,0, 0,0};
        tbl[20] = '{1,0,7,0, 0,0,0,0,0,         0,0,0,0, 0,0, 0,0, 1,0};
        tbl[21] = '{0,0,0,0, 1,0,'h77,0,0,      0,0,0,0, 0,0, 0,0, 1,0};
        tbl[22] = '{0,0,0,0, 0,0,0,0,0,         1,0,7,'h77, 0,0, 0,0, 1,0};
        tbl[23] = '{1,3,9,'h40, 0,0,0,0,0,      0,0,0,0, 0,0, 0,0, 2,0};
        tbl[24] = '{0,0,0,0, 1,1,'h44,1,'h200,  0,0,0,0, 0,0, 0,0, 2,0};
        tbl[25] = '{0,0,0,0, 0,0,0,0,0,         1,1,9,'h44, 0,0, 1,'h200, 2,0};
        tbl[26] = '{0,0,0,0, 0,0,0,0,0,         0,0,0,0, 0,0, 0,0, 0,0};

        do_reset();
        chk("reset_irid", 32'(issue_RobId), 0);
        chk("reset_full", 32'(rob_full), 0);
        chk("reset_cv", 32'(commit_valid), 0);
        chk("reset_jf", 32'(jump_flag), 0);

        foreach (tbl[i]) begin
            issue_valid = 1'(tbl[i].iv);
            issue_type = 2'(tbl[i].ty);
            issue_rd = 5'(tbl[i].rd);
            issue_pc = 32'(tbl[i].pc);
            cdb_valid = 1'(tbl[i].cdv);
            cdb_RobId = 4'(tbl[i].cid);
            cdb_value = 32'(tbl[i].cval);
            cdb_mispredict = 1'(tbl[i].cmis);
            cdb_next_pc = 32'(tbl[i].cnpc);
            step();
            chk($sformatf("vec%0d_cv", i), 32'(commit_valid), 32'(tbl[i].x_cv));
            chk($sformatf("vec%0d_sc", i), 32'(store_commit), 32'(tbl[i].x_sc));
            chk($sformatf("vec%0d_jf", i), 32'(jump_flag), 32'(tbl[i].x_jf));
            chk($sformatf("vec%0d_irid", i), 32'(issue_RobId), 32'(tbl[i].x_irid));
            chk($sformatf("vec%0d_full", i), 32'(rob_full), 32'(tbl[i].x_full));
            if (tbl[i].x_cv != 0) begin
                chk($sformatf("vec%0d_rid", i), 32'(commit_RobId), 32'(tbl[i].x_rid));
                chk($sformatf("vec%0d_dest", i), 32'(commit_dest), 32'(tbl[i].x_dest));
                chk($sformatf("vec%0d_val", i), commit_value, 32'(tbl[i].x_val));
            end
            if (tbl[i].x_sc != 0) chk($sformatf("vec%0d_srid", i), 32'(store_RobId), 32'(tbl[i].x_srid));
            if (tbl[i].x_jf != 0) chk($sformatf("vec%0d_jpc", i), jump_pc, 32'(tbl[i].x_jpc));
        end
        idle();

        // full: 16 allocations, 17th refused, retire frees a slot without same-edge reuse
        do_reset();
        for (int i = 0; i < 16; i++) begin
            issue(0, i + 1, 0);
            step();
        end
        chk("full_after16", 32'(rob_full), 1);
        chk("full_tail_wrapped", 32'(issue_RobId), 0);
        step();
        chk("full_17th_ignored", 32'(issue_RobId), 0);
        chk("full_still", 32'(rob_full), 1);
        idle();
        cdb(0, 32'h5, 0, 0);
        step();
        chk("full_cdb_no_retire", 32'(commit_valid), 0);
        idle();
        issue(0, 4, 0);
        step();
        chk("full_retire_cv", 32'(commit_valid), 1);
        chk("full_retire_rid", 32'(commit_RobId), 0);
        chk("full_cleared", 32'(rob_full), 0);
        chk("full_no_slot_reuse", 32'(issue_RobId), 0);
        step();
        chk("full_refill_irid", 32'(issue_RobId), 1);
        chk("full_refill_full", 32'(rob_full), 1);
        idle();

        // wrap: 20 issue/complete/retire triples walk the tags past 15
        do_reset();
        for (int i = 0; i < 20; i++) begin
            issue(0, (i % 31) + 1, 0);
            step();
            chk("wrap_irid", 32'(issue_RobId), 32'((i + 1) % 16));
            idle();
            cdb(i % 16, 32'(i), 0, 0);
            step();
            idle();
            step();
            chk("wrap_cv", 32'(commit_valid), 1);
            chk("wrap_rid", 32'(commit_RobId), 32'(i % 16));
            chk("wrap_val", commit_value, 32'(i));
            chk("wrap_full", 32'(rob_full), 0);
        end

        // stall: pulse holds while rdy is low and allocation is frozen
        do_reset();
        issue(0, 3, 0);
        step();
        idle();
        cdb(0, 32'h9, 0, 0);
        step();
        idle();
        step();
        chk("stall_cv_pre", 32'(commit_valid), 1);
        rdy = 1'b0;
        issue(0, 4, 0);
        step();
        step();
        chk("stall_cv_held", 32'(commit_valid), 1);
        chk("stall_val_held", commit_value, 32'h9);
        chk("stall_irid_frozen", 32'(issue_RobId), 1);
        idle();
        rdy = 1'b1;
        step();
        chk("stall_cv_drop", 32'(commit_valid), 0);

        // async reset mid-traffic with five entries live and a pulse on the outputs
        do_reset();
        for (int i = 0; i < 6; i++) begin
            issue(0, i + 1, 0);
            step();
        end
        idle();
        cdb(0, 32'hAB, 0, 0);
        step();
        idle();
        step();
        chk("rst_mid_cv_pre", 32'(commit_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_cv", 32'(commit_valid), 0);
        chk("rst_mid_val", commit_value, 0);
        chk("rst_mid_rid", 32'(commit_RobId), 0);
        chk("rst_mid_irid", 32'(issue_RobId), 0);
        chk("rst_mid_full", 32'(rob_full), 0);
        chk("rst_mid_jf", 32'(jump_flag), 0);
        chk("rst_mid_sc", 32'(store_commit), 0);

        // randomized traffic against the queue model
        do_reset();
        q.delete();
        m_tail = 0;
        e_cv = 0;
        e_sc = 0;
        e_jf = 0;
        for (int c = 0; c < 3000; c++) begin
            int cand[$];
            rdy = $urandom_range(0, 9) != 0;
            issue_valid = $urandom_range(0, 2) != 0;
            issue_type = 2'($urandom_range(0, 3));
            issue_rd = 5'($urandom_range(0, 31));
            issue_pc = $urandom;
            cand.delete();
            foreach (q[k]) if (!q[k].done) cand.push_back(k);
            if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
                int k = cand[$urandom_range(0, cand.size() - 1)];
                cdb(q[k].tag, $urandom, (q[k].ty == 1 || q[k].ty == 3) && $urandom_range(0, 7) == 0, $urandom);
            end else if ($urandom_range(0, 4) == 0) begin
                cdb($urandom_range(0, 15), $urandom, 1'($urandom_range(0, 1)), $urandom);
            end else begin
                cdb_valid = 1'b0;
            end
            model_edge();
            step();
            chk("rnd_cv", 32'(commit_valid), 32'(e_cv));
            chk("rnd_sc", 32'(store_commit), 32'(e_sc));
            chk("rnd_jf", 32'(jump_flag), 32'(e_jf));
            chk("rnd_irid", 32'(issue_RobId), 32'(m_tail));
            chk("rnd_full", 32'(rob_full), 32'(q.size() == 16));
            if (e_cv) begin
                chk("rnd_rid", 32'(commit_RobId), 32'(e_rid));
                chk("rnd_dest", 32'(commit_dest), 32'(e_dest));
                chk("rnd_val", commit_value, e_val);
            end
            if (e_sc) chk("rnd_srid", 32'(store_RobId), 32'(e_srid));
            if (e_jf) chk("rnd_jpc", jump_pc, e_jpc);
        end
        idle();
        rdy = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
